riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load/store unit that sits directly downstream of the CPU's EXECUTE stage. It consumes decoded LOAD/STORE operations (funct3, rs1, rs2, immediate, rdId) and performs the word-addressed memory access. It handles byte/halfword lane steering and sign/zero extension, then returns writeback data and a write enable to the register bank. The memory side is a simple request/ready handshake onto the word-indexed instruction/data memory.

Parameters:
ADDR_W, 12, width of word address to memory (4096-word memory)

Ports:
clk  input  1  system clock (divided clock from Clockworks)
reset  input  1  synchronous, active-high reset
start  input  1  operation request; accepted only when busy=0
is_load  input  1  operation is a load (opcode 0000011)
is_store  input  1  operation is a store (opcode 0100011)
funct3  input  3  access size/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
rs1  input  32  base register value
rs2  input  32  store data register value
imm  input  32  sign-extended offset (Iimm for loads, Simm for stores; caller selects)
rd_id  input  5  load destination register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; illegal funct3 (or misaligned, see macro)
wb_en  output  1  valid with done; load completed without error and rd_id != 0
wb_rd  output  5  latched rd_id
wb_data  output  32  extended load result; 0 for stores and errors
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  1 = write, 0 = read; stable while mem_req
mem_addr  output  ADDR_W  word address = ea[ADDR_W+1:2]
mem_wdata  output  32  lane-replicated store data
mem_wmask  output  4  byte write enables; 0000 for reads
mem_rdata  input  32  read data; sampled in the cycle mem_ready=1
mem_ready  input  1  memory accepts/completes the request

Behaviour:
- Reset: state=IDLE. busy, done, err, wb_en, mem_req, mem_we are 0. wb_rd, wb_data, mem_addr, mem_wdata, mem_wmask are 0.
- ea = rs1 + imm, modulo 2^32. off = ea[1:0]. Upper address bits above ADDR_W+1 are ignored.
- Acceptance: start=1 in IDLE with exactly one of is_load/is_store set. In that case latch ea, funct3, rs2, rd_id and kind.
- start with both or neither of is_load/is_store set is ignored. start while busy is ignored.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else is illegal.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ on a legal accept.
  - IDLE -> RESP on an illegal accept; no memory access is made.
  - REQ: mem_req=1 and all mem_* outputs are stable. Leave REQ -> RESP in the first cycle mem_ready=1; capture mem_rdata in that cycle.
  - RESP: done=1 for exactly one cycle, then -> IDLE.
- Latency: start accepted at cycle T; mem_req high at T+1. With mem_ready=1 at T+1, done is high at T+2. Each stall cycle adds one. The next start can be accepted at T+3 at the earliest.
- Stores:
  - SB: wdata={4{rs2[7:0]}}, wmask=0001<<off.
  - SH: wdata={2{rs2[15:0]}}, wmask=0011<<(2*off[1]).
  - SW: wdata=rs2, wmask=1111.
  - wb_en=0, wb_data=0.
- Loads:
  - Byte = mem_rdata[8*off+7:8*off]. Half = mem_rdata[16*off[1]+15:16*off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - wb_en=1 only if rd_id != 0 and err=0.
- mem_ready outside REQ is ignored.
- wb_rd, wb_data, err and wb_en are held from RESP until the next RESP; they are meaningful only while done=1.
- Reset during REQ: mem_req drops in the next cycle, no done is produced, and the transaction is abandoned.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned is LH/LHU/SH with off[0]=1, or LW/SW with off!=0. A misaligned op goes IDLE -> RESP without a memory access and reports done=1, err=1, wb_en=0, wb_data=0.
- Undefined: misaligned ops proceed. Halfword uses off[1] only and word ignores off, i.e. the access is silently aligned down. err asserts only for illegal funct3.

Test Plan:
- LB: rs1=0x10, imm=3, mem_rdata=0x80FF7F01, mem_ready high at T+1 -> mem_addr=4, mem_wmask=0000, done at T+2, wb_data=0xFFFFFF80, wb_en=1. Same with LBU (funct3 100) -> wb_data=0x00000080.
- SH: rs1=0x20, imm=2, rs2=0x1234ABCD -> mem_we=1, mem_addr=8, mem_wmask=1100, mem_wdata=0xABCDABCD, wb_en=0.
- LW with mem_ready held low 3 cycles after mem_req -> mem_req stays high with a stable address for 4 cycles; done exactly one cycle after ready; start pulses while busy are ignored.
- LW with ea=0x6, rd_id=5:
  - With macro: no mem_req, done at T+1, err=1, wb_en=0.
  - Without macro: mem_addr=1, full word returned, err=0.
- Load with rd_id=0 -> done=1, wb_en=0. funct3=011 load -> no mem_req, done at T+1, err=1.
- Assert reset during REQ -> mem_req=0 next cycle, no done pulse, busy=0, all outputs at reset values; a following LW completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: word-addressed memory access with byte/halfword lane steering and extension.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned LH/LHU/SH/LW/SW instead of aligning down.
module riscv_lsu #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       rs1,
  input  logic [31:0]       rs2,
  input  logic [31:0]       imm,
  input  logic [4:0]        rd_id,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] ea;
  logic        accept, legal, misaligned, bad;
  logic [1:0]  off_reg;
  logic [2:0]  funct3_reg;
  logic        is_load_reg;
  logic [4:0]  rd_reg;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] byte_sh, half_sh, ld_data;
  logic        unused_bits;

  assign ea     = rs1 + imm;
  assign accept = (state_reg == IDLE) && start && (is_load ^ is_store);

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                      ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Errors bypass memory entirely and go straight to the response state.
  assign bad = !legal || misaligned;

  always_comb begin
    st_wdata = rs2;
    st_wmask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2[7:0]}};
        st_wmask = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2[15:0]}};
        st_wmask = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2;
        st_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sh = mem_rdata >> {off_reg, 3'b000};
    half_sh = mem_rdata >> {off_reg[1], 4'b0000};
    case (funct3_reg)
      3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  ld_data = {24'd0, byte_sh[7:0]};
      3'b101:  ld_data = {16'd0, half_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  assign unused_bits = ^{ea[31:ADDR_W+2], byte_sh[31:8], half_sh[31:16]};

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = bad ? RESP : REQ;
      REQ:     if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == RESP);
  assign mem_req = (state_reg == REQ);

  // Memory-side outputs are loaded at accept so they stay frozen for the whole request.
  always_ff @(posedge clk) begin
    if (reset) begin
      off_reg     <= '0;
      funct3_reg  <= '0;
      is_load_reg <= 1'b0;
      rd_reg      <= '0;
      err         <= 1'b0;
      wb_en       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else begin
      if (accept) begin
        off_reg     <= ea[1:0];
        funct3_reg  <= funct3;
        is_load_reg <= is_load;
        rd_reg      <= rd_id;
        if (bad) begin
          err     <= 1'b1;
          wb_en   <= 1'b0;
          wb_data <= '0;
          wb_rd   <= rd_id;
        end else begin
          mem_we    <= is_store;
          mem_addr  <= ea[ADDR_W+1:2];
          mem_wdata <= is_store ? st_wdata : 32'd0;
          mem_wmask <= is_store ? st_wmask : 4'b0000;
        end
      end
      if ((state_reg == REQ) && mem_ready) begin
        err     <= 1'b0;
        wb_rd   <= rd_reg;
        wb_en   <= is_load_reg && (rd_reg != 5'd0);
        wb_data <= is_load_reg ? ld_data : 32'd0;
      end
    end
  end
endmodule
